alu_timer_encoder: RTL and testbench

Execution-support unit for the 8-bit, 10-bit-PC single-cycle CPU datapath. It holds three independent functions:
- the combinational 8-bit ALU that feeds the register-file write mux and the zero flip-flop;
- the 4-to-2 interrupt priority encoder that selects the interrupt vector and the PC-source mux;
- the programmable clock divider/timer whose tick, ANDed with an enable, becomes interrupt source 4.

---
 rtl/alu_timer_encoder_pkg.sv | 29 ++
 rtl/alu_timer_encoder_timer_prescaler.sv | 61 ++++++
 rtl/alu_timer_encoder.sv | 72 +++++++
 tb/tb_alu_timer_encoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_timer_encoder_pkg.sv
// Shared definitions for the CPU execution-support unit: ALU opcodes,
// interrupt codes and the prescaler terminal-count helper.
package alu_timer_encoder_pkg;

  typedef enum logic [2:0] {
    ALU_PASS_A = 3'b000,
    ALU_NOT_A  = 3'b001,
    ALU_ADD    = 3'b010,
    ALU_SUB    = 3'b011,
    ALU_AND    = 3'b100,
    ALU_OR     = 3'b101,
    ALU_NEG_A  = 3'b110,
    ALU_NEG_B  = 3'b111
  } alu_op_e;

  localparam logic [1:0] INT_CODE_IE1  = 2'b00;
  localparam logic [1:0] INT_CODE_IE2  = 2'b01;
  localparam logic [1:0] INT_CODE_IE3  = 2'b10;
  localparam logic [1:0] INT_CODE_IE4  = 2'b11;
  localparam logic [1:0] INT_CODE_NONE = 2'b00;

  // Last prescaler value before wrap for a period of 2^sel cycles.
  function automatic logic [6:0] prescale_max(input logic [2:0] sel);
    logic [7:0] w_full;
    w_full = (8'd1 << sel) - 8'd1;
    return w_full[6:0];
  endfunction

endpackage

// File: rtl/alu_timer_encoder_timer_prescaler.sv
// Programmable divider: a 2^div_sel prescaler feeding a div_count main
// counter. Any change of configuration restarts the period from that edge.
module timer_prescaler
  import alu_timer_encoder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] div_sel,
  input  logic [5:0] div_count,
  output logic       tick
);

  logic [6:0] r_p;
  logic [5:0] r_m;
  logic [2:0] r_sel;
  logic [5:0] r_cnt;
  logic       r_tick;

  logic w_cfg_change;
  logic w_p_wrap;
  logic w_m_wrap;

  assign w_cfg_change = (div_sel != r_sel) || (div_count != r_cnt);
  assign w_p_wrap     = (r_p == prescale_max(r_sel));
  assign w_m_wrap     = (r_m == (r_cnt - 6'd1));

  // Counter state; reset captures the live config so release is not a change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p    <= '0;
      r_m    <= '0;
      r_tick <= 1'b0;
      r_sel  <= div_sel;
      r_cnt  <= div_count;
    end else begin
      r_tick <= 1'b0;
      if (w_cfg_change) begin
        r_p   <= '0;
        r_m   <= '0;
        r_sel <= div_sel;
        r_cnt <= div_count;
      end else if (r_cnt == 6'd0) begin
        r_p <= '0;
        r_m <= '0;
      end else if (w_p_wrap) begin
        r_p <= '0;
        if (w_m_wrap) begin
          r_m    <= '0;
          r_tick <= 1'b1;
        end else begin
          r_m <= r_m + 6'd1;
        end
      end else begin
        r_p <= r_p + 7'd1;
      end
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/alu_timer_encoder.sv
// Execution-support unit: combinational ALU, fixed-priority interrupt
// encoder and the timer whose gated tick becomes interrupt source 4.
module alu_timer_encoder
  import alu_timer_encoder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] alu_a,
  input  logic [7:0] alu_b,
  input  logic [2:0] alu_op,
  output logic [7:0] alu_y,
  output logic       alu_z,
  input  logic       ie1,
  input  logic       ie2,
  input  logic       ie3,
  input  logic       ie4,
  output logic [1:0] int_code,
  output logic       int_any,
  input  logic [2:0] div_sel,
  input  logic [5:0] div_count,
  input  logic       timer_en,
  output logic       tick,
  output logic       timer_irq
);

  logic [7:0] w_y;
  logic [1:0] w_code;
  logic       w_tick;

  // ALU result, all arithmetic wraps modulo 256.
  always_comb begin
    w_y = alu_a;
    case (alu_op_e'(alu_op))
      ALU_PASS_A: w_y = alu_a;
      ALU_NOT_A:  w_y = ~alu_a;
      ALU_ADD:    w_y = alu_a + alu_b;
      ALU_SUB:    w_y = alu_a - alu_b;
      ALU_AND:    w_y = alu_a & alu_b;
      ALU_OR:     w_y = alu_a | alu_b;
      ALU_NEG_A:  w_y = 8'h00 - alu_a;
      ALU_NEG_B:  w_y = 8'h00 - alu_b;
      default:    w_y = alu_a;
    endcase
  end

  assign alu_y = w_y;
  assign alu_z = (w_y == 8'h00);

  // Priority encoder: ie1 wins over ie2 over ie3 over ie4.
  always_comb begin
    w_code = INT_CODE_NONE;
    if (ie1)      w_code = INT_CODE_IE1;
    else if (ie2) w_code = INT_CODE_IE2;
    else if (ie3) w_code = INT_CODE_IE3;
    else if (ie4) w_code = INT_CODE_IE4;
  end

  assign int_code = w_code;
  assign int_any  = ie1 | ie2 | ie3 | ie4;

  timer_prescaler u_timer (
    .clk       (clk),
    .reset     (reset),
    .div_sel   (div_sel),
    .div_count (div_count),
    .tick      (w_tick)
  );

  assign tick      = w_tick;
  assign timer_irq = w_tick & timer_en;

endmodule

// File: tb/tb_alu_timer_encoder.sv
// Bench for alu_timer_encoder: vector tables, hand-written timer sequences
// and a randomized run against an arithmetic reference model.
module tb_alu_timer_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_y;
  logic       alu_z;
  logic       ie1, ie2, ie3, ie4;
  logic [1:0] int_code;
  logic       int_any;
  logic [2:0] div_sel;
  logic [5:0] div_count;
  logic       timer_en;
  logic       tick, timer_irq;

  int checks   = 0;
  int failures = 0;

  // Timer reference: edges elapsed since the last (re)start point.
  int         m_elapsed = 0;
  logic [2:0] m_sel     = '0;
  logic [5:0] m_cnt     = '0;
  logic       m_tick    = 1'b0;

  always #5 clk = ~clk;

  alu_timer_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_y     (alu_y),
    .alu_z     (alu_z),
    .ie1       (ie1),
    .ie2       (ie2),
    .ie3       (ie3),
    .ie4       (ie4),
    .int_code  (int_code),
    .int_any   (int_any),
    .div_sel   (div_sel),
    .div_count (div_count),
    .timer_en  (timer_en),
    .tick      (tick),
    .timer_irq (timer_irq)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       z;
  } alu_vec_t;

  typedef struct {
    logic [3:0] ie;   // {ie4, ie3, ie2, ie1}
    logic [1:0] code;
    logic       any;
  } enc_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ai, bi, r;
    ai = int'(a);
    bi = int'(b);
    case (op)
      3'd0: r = ai;
      3'd1: r = 255 - ai;
      3'd2: r = ai + bi;
      3'd3: r = ai - bi + 256;
      3'd4: r = int'(a & b);
      3'd5: r = int'(a | b);
      3'd6: r = 256 - ai;
      default: r = 256 - bi;
    endcase
    return 8'(r % 256);
  endfunction

  function automatic logic [1:0] enc_ref(input logic [3:0] ie);
    for (int i = 0; i < 4; i++)
      if (ie[i]) return 2'(i);
    return 2'd0;
  endfunction

  // One clock: update the model on the rising edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    if (!reset || div_sel != m_sel || div_count != m_cnt) begin
      m_elapsed = 0;
      m_sel     = div_sel;
      m_cnt     = div_count;
      m_tick    = 1'b0;
    end else if (m_cnt == 6'd0) begin
      m_elapsed = 0;
      m_tick    = 1'b0;
    end else begin
      m_elapsed++;
      m_tick = ((m_elapsed % (int'(m_cnt) << m_sel)) == 0);
    end
    @(negedge clk);
    chk("model_tick", 32'(tick), 32'(m_tick));
    chk("model_irq", 32'(timer_irq), 32'(m_tick & timer_en));
  endtask

  alu_vec_t alu_tab[11];
  enc_vec_t enc_tab[5];

  initial begin
    int highs;

    alu_tab[0]  = '{3'd0, 8'h35, 8'h12, 8'h35, 1'b0};
    alu_tab[1]  = '{3'd1, 8'h35, 8'h12, 8'hCA, 1'b0};
    alu_tab[2]  = '{3'd2, 8'h35, 8'h12, 8'h47, 1'b0};
    alu_tab[3]  = '{3'd3, 8'h35, 8'h12, 8'h23, 1'b0};
    alu_tab[4]  = '{3'd4, 8'h35, 8'h12, 8'h10, 1'b0};
    alu_tab[5]  = '{3'd5, 8'h35, 8'h12, 8'h37, 1'b0};
    alu_tab[6]  = '{3'd6, 8'h35, 8'h12, 8'hCB, 1'b0};
    alu_tab[7]  = '{3'd7, 8'h35, 8'h12, 8'hEE, 1'b0};
    alu_tab[8]  = '{3'd3, 8'h7F, 8'h7F, 8'h00, 1'b1};
    alu_tab[9]  = '{3'd2, 8'hFF, 8'h01, 8'h00, 1'b1};
    alu_tab[10] = '{3'd6, 8'h00, 8'h5A, 8'h00, 1'b1};

    enc_tab[0] = '{4'b0000, 2'b00, 1'b0};
    enc_tab[1] = '{4'b0100, 2'b10, 1'b1};
    enc_tab[2] = '{4'b1010, 2'b01, 1'b1};
    enc_tab[3] = '{4'b1111, 2'b00, 1'b1};
    enc_tab[4] = '{4'b1000, 2'b11, 1'b1};

    reset = 1'b0;
    alu_a = '0; alu_b = '0; alu_op = '0;
    {ie4, ie3, ie2, ie1} = 4'b0000;
    div_sel = 3'd4; div_count = 6'd1; timer_en = 1'b1;

    // Reset state
    repeat (3) step();
    chk("reset_tick", 32'(tick), 32'd0);
    chk("reset_irq", 32'(timer_irq), 32'd0);

    // ALU table
    foreach (alu_tab[i]) begin
      alu_op = alu_tab[i].op; alu_a = alu_tab[i].a; alu_b = alu_tab[i].b;
      #1;
      $display("alu op=%0d a=%h b=%h y=%h z=%0d", alu_op, alu_a, alu_b, alu_y, alu_z);
      chk("alu_y", 32'(alu_y), 32'(alu_tab[i].y));
      chk("alu_z", 32'(alu_z), 32'(alu_tab[i].z));
    end

    // Encoder table
    foreach (enc_tab[i]) begin
      {ie4, ie3, ie2, ie1} = enc_tab[i].ie;
      #1;
      $display("enc ie=%b code=%b any=%0d", enc_tab[i].ie, int_code, int_any);
      chk("int_code", 32'(int_code), 32'(enc_tab[i].code));
      chk("int_any", 32'(int_any), 32'(enc_tab[i].any));
    end

    // Period 16 after release; irq gated off from edge 41
    @(negedge clk);
    reset = 1'b1;
    for (int n = 1; n <= 64; n++) begin
      if (n == 41) timer_en = 1'b0;
      step();
      if (tick) $display("tick at edge %0d irq=%0d", n, timer_irq);
      chk("tick_period16", 32'(tick), 32'(n % 16 == 0));
      chk("irq_gate", 32'(timer_irq), 32'((n % 16 == 0) && (n <= 40)));
    end

    // Config change mid-count: next tick 6 edges after the change edge
    repeat (5) step();
    div_sel = 3'd1; div_count = 6'd3; timer_en = 1'b1;
    for (int n = 0; n <= 12; n++) begin
      step();
      if (tick) $display("tick %0d edges after change", n);
      chk("tick_after_change", 32'(tick), 32'((n > 0) && (n % 6 == 0)));
    end

    // Reset while tick is high clears it without waiting for a clock
    reset = 1'b0;
    #1;
    chk("reset_async_tick", 32'(tick), 32'd0);
    chk("reset_async_irq", 32'(timer_irq), 32'd0);
    div_sel = 3'd4; div_count = 6'd1;
    repeat (2) step();
    reset = 1'b1;

    // Reset at count 10 of 16, then a full period after release
    repeat (10) step();
    reset = 1'b0;
    #1;
    chk("reset_mid_tick", 32'(tick), 32'd0);
    step();
    reset = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (tick) $display("tick at edge %0d after mid-count reset", n);
      chk("tick_after_reset", 32'(tick), 32'(n == 16));
    end

    // Disabled timer
    div_count = 6'd0;
    highs = 0;
    repeat (200) begin
      step();
      if (tick) highs++;
    end
    $display("disabled timer: %0d tick cycles in 200", highs);
    chk("disabled_no_tick", 32'(highs), 32'd0);

    // Continuous tick with div_sel=0, div_count=1
    div_sel = 3'd0; div_count = 6'd1;
    step();
    for (int n = 1; n <= 5; n++) begin
      step();
      chk("continuous_tick", 32'(tick), 32'd1);
    end

    // Randomized run against the reference model
    for (int c = 0; c < 300; c++) begin
      alu_op = 3'($urandom_range(0, 7));
      alu_a  = 8'($urandom);
      alu_b  = 8'($urandom);
      {ie4, ie3, ie2, ie1} = 4'($urandom);
      if ($urandom_range(0, 3) == 0) timer_en = ~timer_en;
      if ($urandom_range(0, 39) == 0) begin
        div_sel   = 3'($urandom_range(0, 3));
        div_count = 6'($urandom_range(0, 4));
      end
      reset = ($urandom_range(0, 99) != 0);
      #1;
      $display("rnd %0d op=%0d a=%h b=%h y=%h ie=%b code=%b sel=%0d cnt=%0d rst=%0d",
               c, alu_op, alu_a, alu_b, alu_y, {ie4, ie3, ie2, ie1}, int_code,
               div_sel, div_count, reset);
      chk("rnd_alu_y", 32'(alu_y), 32'(alu_ref(alu_op, alu_a, alu_b)));
      chk("rnd_alu_z", 32'(alu_z), 32'(alu_ref(alu_op, alu_a, alu_b) == 8'h00));
      chk("rnd_int_code", 32'(int_code), 32'(enc_ref({ie4, ie3, ie2, ie1})));
      chk("rnd_int_any", 32'(int_any), 32'({ie4, ie3, ie2, ie1} != 4'b0000));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
